// File: rtl/counter_gen_pkg.sv
// counter_gen_pkg
//   Shared constants and encodings for the counter_gen block.
//   DEF_WIDTH / DEF_PRE_W : default counter and prescaler-setting widths
//   dir_e                 : count direction encoding (UP=1, DOWN=0)
//   sat_e                 : boundary behaviour encoding (WRAP=0, SAT=1)
package counter_gen_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_PRE_W = 4;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  typedef enum logic {
    WRAP = 1'b0,
    SAT  = 1'b1
  } sat_e;

endpackage

// File: rtl/counter_prescaler.sv
// counter_prescaler
//   Divides enabled cycles: emits tick on every (prescale+1)-th cycle with en=1.
//   clk      in  : clock, rising edge
//   rst      in  : synchronous active-high reset
//   en       in  : advance the prescaler this cycle
//   clr      in  : synchronous restart of the prescaler count
//   prescale in  : divide setting (0 = tick on every enabled cycle)
//   tick     out : combinational, high on the enabled cycle that completes a period
module counter_prescaler
  import counter_gen_pkg::*;
#(
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] prescale,
  output logic             tick
);

  logic [PRE_W-1:0] r_cnt;

  assign tick = en && (r_cnt == prescale);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (en) begin
      // The tick cycle itself restarts the period so the next tick is a full
      // prescale+1 enabled cycles away.
      r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/counter_gen.sv
// counter_gen
//   Up/down counter with range 0..modulo, wrap or saturate at the limits,
//   prescaled enable, parallel load, terminal-count pulse and sticky overflow.
//   clk, rst            : clock / synchronous active-high reset
//   en, prescale        : count enable feeding the prescaler; one step per prescale+1 enabled cycles
//   load, load_data     : synchronous load of min(load_data, modulo)
//   dir, sat, modulo    : direction (1=up), saturate (1) or wrap (0), upper limit
//   oe                  : output enable for q_gated / q_oe
//   clr_ovf             : clears the sticky overflow flag
//   q                   : registered count
//   q_gated, q_oe       : q masked by oe, and oe replicated per bit
//   tc                  : one-cycle pulse following each boundary tick
//   ovf                 : sticky boundary flag
module counter_gen
  import counter_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PRE_W = DEF_PRE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             dir,
  input  logic             sat,
  input  logic [WIDTH-1:0] modulo,
  input  logic [PRE_W-1:0] prescale,
  input  logic             oe,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_gated,
  output logic [WIDTH-1:0] q_oe,
  output logic             tc,
  output logic             ovf
);

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_ovf;

  logic             w_tick;
  logic             w_at_bound;
  logic             w_bound_tick;
  logic [WIDTH-1:0] w_q_step;
  logic [WIDTH-1:0] w_load_val;

  // A load restarts the prescale period so the first step after it needs a
  // full prescale+1 enabled cycles.
  counter_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (load),
    .prescale (prescale),
    .tick     (w_tick)
  );

  // Next value on a tick. The up boundary uses >= so a modulo lowered below
  // the current count is honoured at the next up tick; down ticks above the
  // limit simply decrement.
  always_comb begin
    w_at_bound = 1'b0;
    w_q_step   = r_q;
    if (dir == UP) begin
      w_at_bound = (r_q >= modulo);
      if (w_at_bound) begin
        w_q_step = (sat == SAT) ? modulo : '0;
      end else begin
        w_q_step = r_q + 1'b1;
      end
    end else begin
      w_at_bound = (r_q == '0);
      if (w_at_bound) begin
        w_q_step = (sat == SAT) ? '0 : modulo;
      end else begin
        w_q_step = r_q - 1'b1;
      end
    end
  end

  assign w_load_val   = (load_data > modulo) ? modulo : load_data;
  // Load has priority over a tick, so a boundary on a load cycle is ignored.
  assign w_bound_tick = w_tick && w_at_bound && !load;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q   <= '0;
      r_tc  <= 1'b0;
      r_ovf <= 1'b0;
    end else begin
      if (load) begin
        r_q  <= w_load_val;
        r_tc <= 1'b0;
      end else begin
        r_tc <= w_bound_tick;
        if (w_tick) begin
          r_q <= w_q_step;
        end
      end
      // Set wins over a simultaneous clear.
      if (w_bound_tick) begin
        r_ovf <= 1'b1;
      end else if (clr_ovf) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign q   = r_q;
  assign tc  = r_tc;
  assign ovf = r_ovf;

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_pad
      assign q_gated[gi] = r_q[gi] & oe;
      assign q_oe[gi]    = oe;
    end
  endgenerate

endmodule

// File: tb/tb_counter_gen.sv
module tb_counter_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, load, dir, sat, oe, clr_ovf;
  logic [3:0] prescale;

  logic [7:0]  ld8, mod8, q8, qg8, qoe8;
  logic        tc8, ovf8;
  logic [15:0] ld16, mod16, q16, qg16, qoe16;
  logic        tc16, ovf16;

  int n_total = 0;
  int n_bad   = 0;
  int n_cyc   = 0;

  // Reference model state: index 0 = 8-bit build, 1 = 16-bit build.
  int unsigned m_q[2];
  int unsigned m_tc[2];
  int unsigned m_ovf[2];
  int unsigned m_cnt;

  counter_gen #(.WIDTH(8), .PRE_W(4)) dut8 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(ld8),
    .dir(dir), .sat(sat), .modulo(mod8), .prescale(prescale), .oe(oe),
    .clr_ovf(clr_ovf), .q(q8), .q_gated(qg8), .q_oe(qoe8), .tc(tc8), .ovf(ovf8)
  );

  counter_gen #(.WIDTH(16), .PRE_W(4)) dut16 (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_data(ld16),
    .dir(dir), .sat(sat), .modulo(mod16), .prescale(prescale), .oe(oe),
    .clr_ovf(clr_ovf), .q(q16), .q_gated(qg16), .q_oe(qoe16), .tc(tc16), .ovf(ovf16)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h (cyc %0d)", tag, got, exp, n_cyc);
    end
  endtask

  // Behavioural update from the rules: priority rst > load > tick > hold.
  task automatic model_step();
    bit          tick;
    bit          bnd;
    int unsigned lim, val;
    tick = en && (m_cnt == int'(prescale));
    for (int k = 0; k < 2; k++) begin
      lim = (k == 0) ? int'(mod8) : int'(mod16);
      val = (k == 0) ? int'(ld8)  : int'(ld16);
      if (rst) begin
        m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
      end else if (load) begin
        m_q[k]  = (val < lim) ? val : lim;
        m_tc[k] = 0;
        if (clr_ovf) m_ovf[k] = 0;
      end else begin
        bnd = 0;
        if (tick) begin
          if (dir) begin
            if (m_q[k] < lim) m_q[k] = m_q[k] + 1;
            else begin bnd = 1; m_q[k] = sat ? lim : 0; end
          end else begin
            if (m_q[k] > 0) m_q[k] = m_q[k] - 1;
            else begin bnd = 1; m_q[k] = sat ? 0 : lim; end
          end
        end
        m_tc[k] = bnd;
        if (bnd) m_ovf[k] = 1;
        else if (clr_ovf) m_ovf[k] = 0;
      end
    end
    if (rst || load) m_cnt = 0;
    else if (en) m_cnt = tick ? 0 : (m_cnt + 1) % 16;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    n_cyc++;
    $display("cyc %0d rst=%b ld=%b en=%b dir=%b sat=%b oe=%b q8=%0h tc8=%b ovf8=%b q16=%0h tc16=%b ovf16=%b",
             n_cyc, rst, load, en, dir, sat, oe, q8, tc8, ovf8, q16, tc16, ovf16);
    chk("q8",    q8,    m_q[0]);
    chk("tc8",   tc8,   m_tc[0]);
    chk("ovf8",  ovf8,  m_ovf[0]);
    chk("qg8",   qg8,   oe ? m_q[0] : 0);
    chk("qoe8",  qoe8,  oe ? 32'hFF : 0);
    chk("q16",   q16,   m_q[1]);
    chk("tc16",  tc16,  m_tc[1]);
    chk("ovf16", ovf16, m_ovf[1]);
    chk("qg16",  qg16,  oe ? m_q[1] : 0);
    chk("qoe16", qoe16, oe ? 32'hFFFF : 0);
  endtask

  initial begin
    logic [4:0] en_seq;
    rst = 1; en = 0; load = 0; dir = 1; sat = 0; oe = 1; clr_ovf = 0; prescale = 0;
    ld8 = 0; mod8 = 0; ld16 = 0; mod16 = 0;
    m_cnt = 0;
    for (int k = 0; k < 2; k++) begin m_q[k] = 0; m_tc[k] = 0; m_ovf[k] = 0; end
    step(); step();
    chk("rst_q", q8, 0);
    chk("rst_ovf", ovf8, 0);

    // Count 0..9 then wrap to 0 with tc.
    rst = 0; mod8 = 9; mod16 = 9; en = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i < 10) begin
        chk("up_q", q8, i);
        chk("up_tc", tc8, 0);
      end
    end
    chk("wrap_q", q8, 0);
    chk("wrap_tc", tc8, 1);
    chk("wrap_ovf", ovf8, 1);
    step();
    chk("tc_drop", tc8, 0);

    // Saturated down at 0: each tick pulses tc.
    load = 1; ld8 = 0; ld16 = 0; mod8 = 255; mod16 = 255; en = 0;
    step();
    load = 0; dir = 0; sat = 1; en = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("satdn_q", q8, 0);
      chk("satdn_tc", tc8, 1);
    end
    chk("satdn_ovf", ovf8, 1);
    en = 0; clr_ovf = 1;
    step();
    clr_ovf = 0;
    chk("clr_ovf", ovf8, 0);

    // Prescale 3 with en pattern 1,0,1,1,1.
    dir = 1; sat = 0; load = 1; ld8 = 0; ld16 = 0;
    step();
    load = 0; prescale = 3;
    en_seq = 5'b11101;  // bit i applied on step i
    for (int i = 0; i < 5; i++) begin
      en = en_seq[i];
      step();
      if (i < 4) chk("pre_hold", q8, 0);
    end
    chk("pre_inc", q8, 1);
    prescale = 0; en = 0;

    // Load above modulo clamps; load beats the concurrent tick.
    load = 1; ld8 = 200; mod8 = 100; ld16 = 200; mod16 = 100; en = 1;
    step();
    chk("ld_clamp", q8, 100);
    chk("ld_tc", tc8, 0);
    load = 0; en = 0;
    step();

    // Reset overrides load/en with q=57, ovf=1; oe=0 masks the pads.
    load = 1; ld8 = 57; mod8 = 57; ld16 = 57; mod16 = 57; sat = 1; dir = 1;
    step();
    load = 0; en = 1;
    step();
    chk("pre_rst_q", q8, 57);
    chk("pre_rst_ovf", ovf8, 1);
    rst = 1; load = 1; en = 1; oe = 0;
    step();
    chk("rst_ovr_q", q8, 0);
    chk("rst_ovr_ovf", ovf8, 0);
    chk("rst_ovr_qg", qg8, 0);
    chk("rst_ovr_qoe", qoe8, 0);
    rst = 0; load = 0; en = 0; oe = 1; sat = 0;

    // 16-bit full-range wrap, then modulo lowered below q.
    load = 1; ld16 = 16'hFFFF; mod16 = 16'hFFFF; ld8 = 255; mod8 = 255;
    step();
    load = 0; en = 1;
    step();
    chk("w16_q", q16, 0);
    chk("w16_tc", tc16, 1);
    en = 0; load = 1; ld16 = 9; ld8 = 9;
    step();
    load = 0; mod16 = 5; mod8 = 5; en = 1;
    step();
    chk("lower_mod_q", q16, 0);
    en = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 15) == 0);
      en       = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      sat      = 1'($urandom_range(0, 1));
      oe       = 1'($urandom_range(0, 1));
      clr_ovf  = ($urandom_range(0, 7) == 0);
      prescale = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 2));
      if ($urandom_range(0, 31) == 0) begin
        mod8  = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
        mod16 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      end
      ld8  = 8'($urandom);
      ld16 = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 20)) : 16'($urandom);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/counter_gen.md
COUNTER_GEN -- requirements
Module: counter_gen

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the counter width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter PRE_W, default 4, giving the prescaler setting width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  count enable; feeds prescaler.
REQ-006 load  input  1  synchronous parallel load.
REQ-007 load_data  input  WIDTH  value for load.
REQ-008 dir  input  1  1 = count up, 0 = count down.
REQ-009 sat  input  1  1 = saturate at limit, 0 = wrap.
REQ-010 modulo  input  WIDTH  upper limit; count range 0..modulo inclusive.
REQ-011 prescale  input  PRE_W  count step every prescale+1 enabled cycles.
REQ-012 oe  input  1  output enable.
REQ-013 clr_ovf  input  1  clears sticky overflow flag.
REQ-014 q  output  WIDTH  registered count value, always visible.
REQ-015 q_gated  output  WIDTH  q when oe=1, all-zero when oe=0.
REQ-016 q_oe  output  WIDTH  per-bit pad enable, replicated oe.
REQ-017 tc  output  1  registered terminal-count pulse.
REQ-018 ovf  output  1  sticky boundary flag.

Function
REQ-019 Update priority SHALL be rst > load > tick > hold.
REQ-020 Prescaler count SHALL increment on each en=1 cycle, hold on en=0; a tick SHALL occur when en=1 and count==prescale, count returning to 0 that cycle.
REQ-021 prescale=0 SHALL produce a tick on every en=1 cycle.
REQ-022 load SHALL set q to min(load_data, modulo) on the next edge, clear prescaler count, force tc=0, leave ovf unchanged.
REQ-023 Tick with dir=1 and q<modulo SHALL give q+1; with dir=0 and q>0 SHALL give q-1.
REQ-024 Up boundary (dir=1, q>=modulo) on tick: sat=0 -> q=0; sat=1 -> q=modulo.
REQ-025 Down boundary (dir=0, q==0) on tick: sat=0 -> q=modulo; sat=1 -> q=0.
REQ-026 tc SHALL be 1 for exactly the cycle after each boundary tick (concurrent with the post-boundary q), else 0; repeated boundary ticks while saturated SHALL each pulse tc.
REQ-027 ovf SHALL set on any boundary tick and clear on clr_ovf; simultaneous set and clear SHALL leave ovf=1.
REQ-028 modulo=0 SHALL hold q=0 with every tick a boundary tick.
REQ-029 modulo lowered below current q SHALL take effect at the next tick via the >= rule of REQ-024 (down ticks decrement normally).
REQ-030 q_gated and q_oe SHALL be combinational from q and oe with no added latency.
REQ-031 Arithmetic SHALL be WIDTH-bit unsigned; no intermediate carry SHALL reach q.

Reset
REQ-032 rst=1 at an edge SHALL set q=0, prescaler count=0, tc=0, ovf=0, overriding load and en.
REQ-033 rst asserted mid-prescale or mid-pulse SHALL discard partial state; first tick after release needs a full prescale+1 enabled cycles.
REQ-034 Outputs SHALL be defined (q_gated=0 when oe=0) during reset.

Structure
REQ-035 Package counter_gen_pkg SHALL hold default WIDTH/PRE_W constants and the dir (UP=1/DOWN=0) and sat (WRAP=0/SAT=1) encodings.
REQ-036 The prescaler SHALL be a separate sub-module counter_prescaler (inputs clk, rst, en, clr, prescale; output tick).
REQ-037 Implementation SHALL contain no latches, no asynchronous logic, and no clock gating.

Verification
REQ-038 WIDTH=8, modulo=9, dir=1, sat=0, prescale=0, en=1 from reset: q runs 0..9, 0; tc=1 only on the cycle q returns to 0; ovf=1.
REQ-039 modulo=255, dir=0, sat=1, q=0, en=1 for 3 cycles: q stays 0, tc pulses 3 times, ovf=1; clr_ovf with no tick -> ovf=0.
REQ-040 prescale=3, en toggling 1,0,1,1,1: exactly one increment, after the 4th en=1 cycle.
REQ-041 load_data=200 with modulo=100 and en=1 same cycle: q=100, tc=0, no increment that cycle.
REQ-042 rst asserted with load=1, en=1, q=57, ovf=1: next cycle q=0, ovf=0, tc=0; oe=0 gives q_gated=0, q_oe=0.
REQ-043 WIDTH=16 build: modulo=0xFFFF up-wrap 0xFFFF -> 0x0000 with tc pulse; modulo lowered to 5 while q=9, dir=1 -> next tick q=0.
